// File: rtl/spectrum_pkg.sv
// spectrum_pkg
// Shared definitions for the spectrum peak-hold block.
//   - DEF_* : default build configuration (32-bit complex words, 32 bins,
//             4-bit bar levels, >>12 magnitude scaling, 4-frame hold)
//   - HALF  : width of each signed real/imaginary half-word
//   - LMAX  : largest representable bar level
//   - CNT_W : width of a per-bin hold counter
//   - state_t : frame sequencer states
package spectrum_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_N           = 32;
    localparam int DEF_LEVEL_BITS  = 4;
    localparam int DEF_SHIFT       = 12;
    localparam int DEF_HOLD_FRAMES = 4;

    localparam int HALF  = DEF_WIDTH / 2;
    localparam int LMAX  = (2 ** DEF_LEVEL_BITS) - 1;
    localparam int CNT_W = $clog2(DEF_HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        PUBLISH
    } state_t;

endpackage

// File: rtl/bin_magnitude.sv
// bin_magnitude
// Converts one complex FFT bin into a saturated bar level.
// Magnitude is approximated as |re| + |im|, scaled down by SHIFT and
// clamped to 2^LEVEL_BITS-1. Purely combinational.
// Ports:
//   re   in  signed WIDTH/2   real part
//   im   in  signed WIDTH/2   imaginary part
//   lvl  out LEVEL_BITS       saturated bar level
module bin_magnitude #(
    parameter int WIDTH      = 32,
    parameter int SHIFT      = 12,
    parameter int LEVEL_BITS = 4
) (
    input  logic signed [WIDTH/2-1:0] re,
    input  logic signed [WIDTH/2-1:0] im,
    output logic        [LEVEL_BITS-1:0] lvl
);

    localparam int HW = WIDTH / 2;
    localparam logic [HW:0] LMAX_EXT = (HW + 1)'((2 ** LEVEL_BITS) - 1);

    logic [HW:0] re_abs;
    logic [HW:0] im_abs;
    logic [HW:0] mag;
    logic [HW:0] scaled;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        // Sign-extend by one bit before negating so that the most negative
        // half-word maps to +2^(HW-1) instead of wrapping.
        re_abs = re[HW-1] ? -{re[HW-1], re} : {re[HW-1], re};
        im_abs = im[HW-1] ? -{im[HW-1], im} : {im[HW-1], im};
        mag    = re_abs + im_abs;
        scaled = mag >> SHIFT;
        lvl    = (scaled > LMAX_EXT) ? LMAX_EXT[LEVEL_BITS-1:0]
                                     : scaled[LEVEL_BITS-1:0];
    end

endmodule

// File: rtl/spectrum_peak_hold.sv
// spectrum_peak_hold
// Takes one N-bin FFT frame, converts each bin to a bar level (one bin per
// cycle), applies per-bin peak-hold with timed decay, then publishes all N
// levels at once with a one-cycle levels_valid strobe.
// Build option: define SPECTRUM_PEAK_HOLD_EN to enable peak-hold/decay;
// otherwise the published level is the instantaneous level. Timing is the
// same in both builds (one frame per N+2 cycles).
// Ports:
//   clk           in   clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   frame_valid   in   frame_in carries a frame this cycle
//   frame_in      in   WIDTH x N, bin-indexed {re, im} words
//   frame_ready   out  high in IDLE (combinational)
//   level         out  LEVEL_BITS x N published levels, registered
//   levels_valid  out  one-cycle strobe when level updates
//   busy          out  inverse of frame_ready
module spectrum_peak_hold
    import spectrum_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N           = DEF_N,
    parameter int LEVEL_BITS  = DEF_LEVEL_BITS,
    parameter int SHIFT       = DEF_SHIFT,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    input  logic [WIDTH-1:0]      frame_in [N],
    output logic                  frame_ready,
    output logic [LEVEL_BITS-1:0] level [N],
    output logic                  levels_valid,
    output logic                  busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (SHIFT > WIDTH / 2 || HOLD_FRAMES < 0 || N < 2) begin : g_bad_cfg
        $error("spectrum_peak_hold: unsupported parameter combination");
    end

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [WIDTH-1:0]      frame_q [N];
    logic [WIDTH-1:0]      cur_word;
    logic [LEVEL_BITS-1:0] lvl;
    logic [LEVEL_BITS-1:0] held [N];

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    logic [HOLD_W-1:0] cnt [N];
`endif

    assign frame_ready = (state == IDLE);
    assign busy        = !frame_ready;
    assign cur_word    = frame_q[idx];

    bin_magnitude #(
        .WIDTH      (WIDTH),
        .SHIFT      (SHIFT),
        .LEVEL_BITS (LEVEL_BITS)
    ) u_mag (
        .re  (cur_word[WIDTH-1:WIDTH/2]),
        .im  (cur_word[WIDTH/2-1:0]),
        .lvl (lvl)
    );

    // NOTE: the frame register is pure payload, only read while PROC walks it
    // after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (frame_ready && frame_valid) begin
            frame_q <= frame_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            levels_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                level[i] <= '0;
                held[i]  <= '0;
`ifdef SPECTRUM_PEAK_HOLD_EN
                cnt[i]   <= '0;
`endif
            end
        end else begin
            levels_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_valid) begin
                        state <= PROC;
                        idx   <= '0;
                    end
                end
                PROC: begin
`ifdef SPECTRUM_PEAK_HOLD_EN
                    // A new peak (or an equal one) restarts the hold timer;
                    // decay only begins once the timer has run out.
                    if (lvl >= held[idx]) begin
                        held[idx] <= lvl;
                        cnt[idx]  <= HOLD_LOAD;
                    end else if (cnt[idx] != '0) begin
                        cnt[idx]  <= cnt[idx] - 1'b1;
                    end else if (held[idx] != '0) begin
                        held[idx] <= held[idx] - 1'b1;
                    end
`else
                    held[idx] <= lvl;
`endif
                    if (idx == LAST_IDX) begin
                        state <= PUBLISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PUBLISH: begin
                    level        <= held;
                    levels_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// tb_spectrum_peak_hold
// Self-checking bench for spectrum_peak_hold: directed frames (reset,
// single bin, saturation, peak-hold decay, busy drop, reset abort) plus
// randomized frames, all compared against a frame-level reference model.
module tb_spectrum_peak_hold;

    localparam int WIDTH       = 32;
    localparam int N           = 32;
    localparam int LEVEL_BITS  = 4;
    localparam int SHIFT       = 12;
    localparam int HOLD_FRAMES = 4;
    localparam int LMAX        = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  frame_valid;
    logic [WIDTH-1:0]      frame_in [N];
    logic                  frame_ready;
    logic [LEVEL_BITS-1:0] level [N];
    logic                  levels_valid;
    logic                  busy;

    logic [WIDTH-1:0] stim [N];
    logic [WIDTH-1:0] intr [N];

    int m_held  [N];
    int m_cnt   [N];
    int m_level [N];

    int n_checks = 0;
    int n_fail   = 0;
    int last_wait;

    always #5 clk = ~clk;

    spectrum_peak_hold #(
        .WIDTH       (WIDTH),
        .N           (N),
        .LEVEL_BITS  (LEVEL_BITS),
        .SHIFT       (SHIFT),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .frame_in     (frame_in),
        .frame_ready  (frame_ready),
        .level        (level),
        .levels_valid (levels_valid),
        .busy         (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_lvl(input logic [WIDTH-1:0] w);
        int re, im, mag, l;
        re  = int'($signed(w[WIDTH-1:WIDTH/2]));
        im  = int'($signed(w[WIDTH/2-1:0]));
        mag = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        l   = mag / (2 ** SHIFT);
        return (l > LMAX) ? LMAX : l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_held[i]  = 0;
            m_cnt[i]   = 0;
            m_level[i] = 0;
        end
    endtask

    task automatic model_frame();
        int l;
        for (int i = 0; i < N; i++) begin
            l = ref_lvl(stim[i]);
`ifdef SPECTRUM_PEAK_HOLD_EN
            if (l >= m_held[i]) begin
                m_held[i] = l;
                m_cnt[i]  = HOLD_FRAMES;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
            end else if (m_held[i] > 0) begin
                m_held[i]--;
            end
`else
            m_held[i] = l;
`endif
            m_level[i] = m_held[i];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [WIDTH-1:0] mk(input int re, input int im);
        logic [WIDTH/2-1:0] r, m;
        r = (WIDTH/2)'(re);
        m = (WIDTH/2)'(im);
        return {r, m};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < N; i++) stim[i] = '0;
    endtask

    task automatic random_frame(output logic [WIDTH-1:0] f [N]);
        int mode;
        for (int i = 0; i < N; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: f[i] = '0;
                1: f[i] = $urandom;
                2: f[i] = mk(int'($urandom_range(0, 16383)) - 8192,
                             int'($urandom_range(0, 16383)) - 8192);
                default: f[i] = mk(($urandom_range(0, 1) != 0) ? -32768 : 32767,
                                   ($urandom_range(0, 1) != 0) ? -32768 : 32767);
            endcase
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        frame_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_levels(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_level%0d", tag, i), int'(level[i]), m_level[i]);
    endtask

    // Idle cycles: no strobe may appear and level must hold.
    task automatic idle(input int cycles, input string tag);
        int strobes = 0, drift = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (levels_valid) strobes++;
            for (int i = 0; i < N; i++)
                if (int'(level[i]) != m_level[i]) drift++;
        end
        check({tag, "_idle_strobes"}, strobes, 0);
        check({tag, "_idle_level_drift"}, drift, 0);
    endtask

    // Offers stim, follows it through PROC/PUBLISH and checks timing and
    // levels. intr_at > 0 presents the intr frame just before edge E(intr_at).
    task automatic run_frame(input string tag, input int intr_at);
        int strobe_at = -1, strobes = 0, ready_early = 0;
        last_wait = 0;
        while (!frame_ready && last_wait < 200) begin
            @(posedge clk);
            #1;
            last_wait++;
        end
        check({tag, "_ready_wait"}, int'(frame_ready), 1);
        frame_valid = 1'b1;
        for (int i = 0; i < N; i++) frame_in[i] = stim[i];
        @(posedge clk);                       // E0
        #1;
        frame_valid = 1'b0;
        check({tag, "_busy_after_accept"}, int'(busy), 1);
        model_frame();
        for (int k = 1; k <= N + 1; k++) begin
            if (k == intr_at) begin
                frame_valid = 1'b1;
                for (int i = 0; i < N; i++) frame_in[i] = intr[i];
                check({tag, "_ready_at_intrusion"}, int'(frame_ready), 0);
            end
            @(posedge clk);
            #1;
            frame_valid = 1'b0;
            if (levels_valid) begin
                strobes++;
                if (strobe_at < 0) strobe_at = k;
            end
            if (frame_ready && k <= N) ready_early++;
        end
        check({tag, "_strobe_edge"}, strobe_at, N + 1);
        check({tag, "_strobe_count"}, strobes, 1);
        check({tag, "_ready_early"}, ready_early, 0);
        check({tag, "_ready_after_publish"}, int'(frame_ready), 1);
        check_levels(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int sum;
        int exp5;

        rst = 1'b1;
        frame_valid = 1'b0;
        for (int i = 0; i < N; i++) frame_in[i] = '0;

        // Reset
        do_reset(2);
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(level[i]);
        check("reset_level_sum", sum, 0);
        check("reset_levels_valid", int'(levels_valid), 0);
        check("reset_frame_ready", int'(frame_ready), 1);
        check("reset_busy", int'(busy), 0);

        // Single bin: |0x3000| + |0xD000| = 0x6000 -> 6
        clear_stim();
        stim[3] = 32'h3000_D000;
        run_frame("single", 0);
        check("single_bin3_const", int'(level[3]), 6);
        check("single_bin4_const", int'(level[4]), 0);
        idle(2, "single");

        // Saturation: 65536>>12 = 16 -> 15; 32767>>12 = 7
        clear_stim();
        stim[0] = 32'h8000_8000;
        stim[1] = 32'h7FFF_0000;
        run_frame("sat", 0);
        check("sat_bin0_const", int'(level[0]), 15);
        check("sat_bin1_const", int'(level[1]), 7);

        // Peak hold on bin 5: 0x5000+0x5000 = 40960 -> 10, then zero frames
        do_reset(1);
        for (int s = 1; s <= 15; s++) begin
            clear_stim();
            if (s == 1) stim[5] = mk(20480, 20480);
            run_frame($sformatf("peak%0d", s), 0);
`ifdef SPECTRUM_PEAK_HOLD_EN
            exp5 = (s <= 5) ? 10 : ((10 - (s - 5)) > 0 ? 10 - (s - 5) : 0);
`else
            exp5 = (s == 1) ? 10 : 0;
`endif
            check($sformatf("peak_strobe%0d_bin5", s), int'(level[5]), exp5);
        end

        // Busy: second frame offered at E5 is dropped; back-to-back accept at E(N+2)
        random_frame(stim);
        random_frame(intr);
        run_frame("busy", 5);
        random_frame(stim);
        run_frame("b2b", 0);
        check("b2b_no_wait", last_wait, 0);

        // Reset abort during PROC
        random_frame(stim);
        run_frame("pre_abort", 0);
        random_frame(stim);
        frame_valid = 1'b1;
        for (int i = 0; i < N; i++) frame_in[i] = stim[i];
        @(posedge clk);                       // E0
        #1;
        frame_valid = 1'b0;
        repeat (9) @(posedge clk);            // E1..E9
        #1;
        rst = 1'b1;
        @(posedge clk);                       // E10
        #1;
        rst = 1'b0;
        model_reset();
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(level[i]);
        check("abort_level_sum", sum, 0);
        check("abort_frame_ready", int'(frame_ready), 1);
        check("abort_levels_valid", int'(levels_valid), 0);
        idle(N + 4, "abort");
        random_frame(stim);
        run_frame("post_abort", 0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            random_frame(stim);
            run_frame($sformatf("rand%0d", f), 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
